gol_run_ctrl: RTL and testbench

// - Top-level sequencer for the Game of Life core: starts rom_loader to fill the field, then schedules

---
 rtl/gol_run_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_gol_run_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gol_run_ctrl.sv
// Game of Life run sequencer: field load, periodic stepping, pause/reload, generation count.
// Optional macro GOL_RUN_CTRL_SINGLE_STEP_EN adds i_single_step (advance one generation while paused).
module gol_run_ctrl #(
  parameter int unsigned STEP_PERIOD = 50_000_000,
  parameter int unsigned GEN_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic                 i_pause,
  input  logic                 i_reload,
  input  logic                 i_loader_busy,
  input  logic                 i_step_done,
`ifdef GOL_RUN_CTRL_SINGLE_STEP_EN
  input  logic                 i_single_step,
`endif
  output logic                 o_load_go,
  output logic                 o_step_go,
  output logic [1:0]           o_mem_owner,
  output logic                 o_running,
  output logic [GEN_CNT_W-1:0] o_gen_count
);

  localparam int unsigned     PER_W    = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(STEP_PERIOD - 1);
  localparam logic [1:0]      OWN_DISP = 2'd0;
  localparam logic [1:0]      OWN_LOAD = 2'd1;
  localparam logic [1:0]      OWN_STEP = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_ARM = 3'd1,
    S_LOADING  = 3'd2,
    S_RUN_WAIT = 3'd3,
    S_STEPPING = 3'd4,
    S_PAUSED   = 3'd5
  } state_t;

  state_t                 r_state;
  logic [PER_W-1:0]       r_pre;
  logic                   r_pend_pause;
  logic                   r_pend_reload;
  logic                   r_single;
  logic                   r_load_go;
  logic                   r_step_go;
  logic [1:0]             r_mem_owner;
  logic                   r_running;
  logic [GEN_CNT_W-1:0]   r_gen;

  state_t                 w_state_nxt;
  logic [PER_W-1:0]       w_pre_nxt;
  logic                   w_pend_pause_nxt;
  logic                   w_pend_reload_nxt;
  logic                   w_single_nxt;
  logic                   w_load_go_nxt;
  logic                   w_step_go_nxt;
  logic [1:0]             w_mem_owner_nxt;
  logic                   w_running_nxt;
  logic [GEN_CNT_W-1:0]   w_gen_nxt;
  logic                   w_eff_reload;
  logic                   w_eff_pause;
  logic                   w_single_step;

`ifdef GOL_RUN_CTRL_SINGLE_STEP_EN
  assign w_single_step = i_single_step;
`else
  assign w_single_step = 1'b0;
`endif

  // Requests seen during STEPPING, folded with this cycle's pulses; reload discards a same-cycle pause.
  assign w_eff_reload = r_pend_reload | i_reload;
  assign w_eff_pause  = i_reload ? r_pend_pause : (r_pend_pause ^ i_pause);

  // State register plus registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pre         <= '0;
      r_pend_pause  <= 1'b0;
      r_pend_reload <= 1'b0;
      r_single      <= 1'b0;
      r_load_go     <= 1'b0;
      r_step_go     <= 1'b0;
      r_mem_owner   <= OWN_DISP;
      r_running     <= 1'b0;
      r_gen         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pre         <= w_pre_nxt;
      r_pend_pause  <= w_pend_pause_nxt;
      r_pend_reload <= w_pend_reload_nxt;
      r_single      <= w_single_nxt;
      r_load_go     <= w_load_go_nxt;
      r_step_go     <= w_step_go_nxt;
      r_mem_owner   <= w_mem_owner_nxt;
      r_running     <= w_running_nxt;
      r_gen         <= w_gen_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt       = r_state;
    w_pre_nxt         = r_pre;
    w_pend_pause_nxt  = r_pend_pause;
    w_pend_reload_nxt = r_pend_reload;
    w_single_nxt      = r_single;
    w_load_go_nxt     = 1'b0;
    w_step_go_nxt     = 1'b0;
    w_gen_nxt         = r_gen;

    case (r_state)
      S_IDLE: begin
        if (i_start | i_reload) begin
          w_state_nxt   = S_LOAD_ARM;
          w_load_go_nxt = 1'b1;
        end
      end

      S_LOAD_ARM: begin
        if (i_loader_busy) begin
          w_state_nxt = S_LOADING;
        end
      end

      S_LOADING: begin
        if (!i_loader_busy) begin
          w_state_nxt = S_RUN_WAIT;
          w_pre_nxt   = '0;
          w_gen_nxt   = '0;
        end
      end

      S_RUN_WAIT: begin
        if (i_reload) begin
          w_state_nxt   = S_LOAD_ARM;
          w_load_go_nxt = 1'b1;
        end else if (i_pause) begin
          w_state_nxt = S_PAUSED;
        end else if (r_pre == PER_LAST) begin
          w_state_nxt       = S_STEPPING;
          w_step_go_nxt     = 1'b1;
          w_pend_pause_nxt  = 1'b0;
          w_pend_reload_nxt = 1'b0;
          w_single_nxt      = 1'b0;
        end else begin
          w_pre_nxt = PER_W'(r_pre + PER_W'(1));
        end
      end

      S_STEPPING: begin
        if (i_step_done) begin
          w_gen_nxt         = GEN_CNT_W'(r_gen + GEN_CNT_W'(1));
          w_pend_pause_nxt  = 1'b0;
          w_pend_reload_nxt = 1'b0;
          w_single_nxt      = 1'b0;
          if (w_eff_reload) begin
            w_state_nxt   = S_LOAD_ARM;
            w_load_go_nxt = 1'b1;
          end else if (r_single | w_eff_pause) begin
            // A single step always lands back in PAUSED.
            w_state_nxt = S_PAUSED;
          end else begin
            w_state_nxt = S_RUN_WAIT;
            w_pre_nxt   = '0;
          end
        end else begin
          w_pend_pause_nxt  = w_eff_pause;
          w_pend_reload_nxt = w_eff_reload;
        end
      end

      S_PAUSED: begin
        if (i_reload) begin
          w_state_nxt   = S_LOAD_ARM;
          w_load_go_nxt = 1'b1;
        end else if (i_pause) begin
          w_state_nxt = S_RUN_WAIT;
          w_pre_nxt   = '0;
        end else if (w_single_step) begin
          w_state_nxt       = S_STEPPING;
          w_step_go_nxt     = 1'b1;
          w_pend_pause_nxt  = 1'b0;
          w_pend_reload_nxt = 1'b0;
          w_single_nxt      = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    case (w_state_nxt)
      S_LOAD_ARM, S_LOADING: w_mem_owner_nxt = OWN_LOAD;
      S_STEPPING:            w_mem_owner_nxt = OWN_STEP;
      default:               w_mem_owner_nxt = OWN_DISP;
    endcase
    w_running_nxt = (w_state_nxt == S_RUN_WAIT) || (w_state_nxt == S_STEPPING);
  end

  assign o_load_go   = r_load_go;
  assign o_step_go   = r_step_go;
  assign o_mem_owner = r_mem_owner;
  assign o_running   = r_running;
  assign o_gen_count = r_gen;

endmodule

// File: tb/tb_gol_run_ctrl.sv
// Bench for gol_run_ctrl: cycle reference model with loader/stepper behaviour models,
// directed scenarios followed by randomized control pulses.
module tb_gol_run_ctrl;

  localparam int STEP_PERIOD = 4;
  localparam int GEN_CNT_W   = 4;
  localparam int LOAD_CYC    = 15;
  localparam int STEP_CYC    = 6;

  localparam int M_IDLE = 0, M_ARM = 1, M_LOAD = 2, M_RUN = 3, M_STEP = 4, M_PAUSE = 5;
  localparam int C_OWN0 = 0, C_OWN2 = 1, C_LOADGO = 2, C_STEPGO = 3, C_GEN15 = 4, C_GENNOT15 = 5,
                 C_BUSY = 6, C_RUNWAIT = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic                 i_start;
  logic                 i_pause;
  logic                 i_reload;
  logic                 i_loader_busy;
  logic                 i_step_done;
  logic                 i_single_step;
  logic                 o_load_go;
  logic                 o_step_go;
  logic [1:0]           o_mem_owner;
  logic                 o_running;
  logic [GEN_CNT_W-1:0] o_gen_count;

  gol_run_ctrl #(.STEP_PERIOD(STEP_PERIOD), .GEN_CNT_W(GEN_CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .i_pause       (i_pause),
    .i_reload      (i_reload),
    .i_loader_busy (i_loader_busy),
    .i_step_done   (i_step_done),
`ifdef GOL_RUN_CTRL_SINGLE_STEP_EN
    .i_single_step (i_single_step),
`endif
    .o_load_go     (o_load_go),
    .o_step_go     (o_step_go),
    .o_mem_owner   (o_mem_owner),
    .o_running     (o_running),
    .o_gen_count   (o_gen_count)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: mode, elapsed-time anchor for the step timer, counters.
  int m_mode   = M_IDLE;
  int m_entry  = 0;
  int m_gen    = 0;
  bit m_pp     = 1'b0;
  bit m_pr     = 1'b0;
  bit m_single = 1'b0;
  bit e_load_go, e_step_go, e_running;
  int e_owner;
  int cyc_n    = 0;
  int busy_left = 0;
  int step_left = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit s, input bit p, input bit r, input bit b, input bit d,
                            input bit ss, input bit rs);
    bit rr, pp;
    e_load_go = 1'b0;
    e_step_go = 1'b0;
    if (!rs) begin
      m_mode = M_IDLE; m_gen = 0; m_pp = 1'b0; m_pr = 1'b0; m_single = 1'b0;
    end else begin
      case (m_mode)
        M_IDLE:  if (s || r) begin m_mode = M_ARM; e_load_go = 1'b1; end
        M_ARM:   if (b) m_mode = M_LOAD;
        M_LOAD:  if (!b) begin m_mode = M_RUN; m_entry = cyc_n; m_gen = 0; end
        M_RUN: begin
          if (r) begin m_mode = M_ARM; e_load_go = 1'b1; end
          else if (p) m_mode = M_PAUSE;
          else if (cyc_n - m_entry == STEP_PERIOD) begin
            m_mode = M_STEP; e_step_go = 1'b1; m_single = 1'b0; m_pp = 1'b0; m_pr = 1'b0;
          end
        end
        M_STEP: begin
          rr = m_pr || r;
          pp = r ? m_pp : (m_pp ^ p);
          if (d) begin
            m_gen = (m_gen + 1) % (1 << GEN_CNT_W);
            if (rr) begin m_mode = M_ARM; e_load_go = 1'b1; end
            else if (m_single || pp) m_mode = M_PAUSE;
            else begin m_mode = M_RUN; m_entry = cyc_n; end
          end else begin
            m_pr = rr; m_pp = pp;
          end
        end
        M_PAUSE: begin
          if (r) begin m_mode = M_ARM; e_load_go = 1'b1; end
          else if (p) begin m_mode = M_RUN; m_entry = cyc_n; end
`ifdef GOL_RUN_CTRL_SINGLE_STEP_EN
          else if (ss) begin
            m_mode = M_STEP; e_step_go = 1'b1; m_single = 1'b1; m_pp = 1'b0; m_pr = 1'b0;
          end
`endif
        end
        default: m_mode = M_IDLE;
      endcase
    end
    if (!rs) begin
      e_owner = 0;
    end else begin
      e_owner = (m_mode == M_ARM || m_mode == M_LOAD) ? 1 : (m_mode == M_STEP) ? 2 : 0;
    end
    e_running = (m_mode == M_RUN) || (m_mode == M_STEP);
  endtask

  // One clock: apply current inputs, compare all outputs, then update loader/stepper models.
  task automatic cyc();
    bit s, p, r, b, d, ss, rs, pl, ps;
    s = i_start; p = i_pause; r = i_reload; b = i_loader_busy; d = i_step_done;
    ss = i_single_step; rs = rst_n;
    pl = o_load_go; ps = o_step_go;
    @(posedge clk);
    #1;
    cyc_n++;
    model_step(s, p, r, b, d, ss, rs);
    check("load_go",   32'(o_load_go),   32'(e_load_go));
    check("step_go",   32'(o_step_go),   32'(e_step_go));
    check("mem_owner", 32'(o_mem_owner), 32'(e_owner));
    check("running",   32'(o_running),   32'(e_running));
    check("gen_count", 32'(o_gen_count), 32'(m_gen));
    i_start = 1'b0; i_pause = 1'b0; i_reload = 1'b0; i_single_step = 1'b0;
    i_step_done = 1'b0;
    if (!rs) begin
      busy_left = 0; step_left = 0; i_loader_busy = 1'b0;
    end else begin
      if (pl) busy_left = LOAD_CYC;
      if (busy_left > 0) begin i_loader_busy = 1'b1; busy_left--; end
      else i_loader_busy = 1'b0;
      if (ps) step_left = STEP_CYC - 1;
      else if (step_left > 0) begin
        step_left--;
        if (step_left == 0) i_step_done = 1'b1;
      end
    end
  endtask

  function automatic bit cond(input int k);
    case (k)
      C_OWN0:     return o_mem_owner == 2'd0;
      C_OWN2:     return o_mem_owner == 2'd2;
      C_LOADGO:   return o_load_go == 1'b1;
      C_STEPGO:   return o_step_go == 1'b1;
      C_GEN15:    return o_gen_count == 4'd15;
      C_GENNOT15: return o_gen_count != 4'd15;
      C_BUSY:     return i_loader_busy == 1'b1;
      C_RUNWAIT:  return o_running && (o_mem_owner == 2'd0);
      default:    return 1'b0;
    endcase
  endfunction

  task automatic wait_cond(input int k, input int budget, input string tag);
    int n;
    n = 0;
    while (!cond(k) && n < budget) begin
      cyc();
      n++;
    end
    check(tag, 32'(cond(k)), 32'd1);
  endtask

  initial begin
    int n, exp_g;
    rst_n = 1'b0; i_start = 1'b0; i_pause = 1'b0; i_reload = 1'b0;
    i_loader_busy = 1'b0; i_step_done = 1'b0; i_single_step = 1'b0;

    repeat (3) cyc();
    check("rst_owner", 32'(o_mem_owner), 32'd0);
    check("rst_gen",   32'(o_gen_count), 32'd0);
    rst_n = 1'b1;
    repeat (2) cyc();

    // Start and load.
    i_start = 1'b1;
    cyc();
    check("t1_load_go", 32'(o_load_go), 32'd1);
    check("t1_owner_load", 32'(o_mem_owner), 32'd1);
    cyc();
    check("t1_load_go_once", 32'(o_load_go), 32'd0);
    wait_cond(C_OWN0, 40, "t1_load_done_timeout");
    check("t1_running", 32'(o_running), 32'd1);
    check("t1_gen0", 32'(o_gen_count), 32'd0);

    // Free run through a counter wrap, then the step period.
    wait_cond(C_GEN15, 400, "t2_gen15_timeout");
    wait_cond(C_GENNOT15, 30, "t2_wrap_timeout");
    check("t2_wrap", 32'(o_gen_count), 32'd0);
    wait_cond(C_STEPGO, 20, "t2_stepgo_timeout");
    cyc();
    n = 1;
    while (!o_step_go && n < 30) begin cyc(); n++; end
    check("t2_period", 32'(n), 32'(STEP_PERIOD + STEP_CYC + 1));

    // Pause in RUN_WAIT, hold, resume.
    wait_cond(C_RUNWAIT, 20, "t3_runwait_timeout");
    i_pause = 1'b1;
    cyc();
    check("t3_paused", 32'(o_running), 32'd0);
    n = 0;
    repeat (20) begin cyc(); if (o_step_go) n++; end
    check("t3_no_step", 32'(n), 32'd0);
    i_pause = 1'b1;
    cyc();
    n = 0;
    while (!o_step_go && n < 10) begin cyc(); n++; end
    check("t3_resume_latency", 32'(n), 32'(STEP_PERIOD));

    // Pause and reload together while stepping: reload wins.
    wait_cond(C_OWN2, 20, "t4_stepping_timeout");
    exp_g = (m_gen + 1) % (1 << GEN_CNT_W);
    i_pause = 1'b1; i_reload = 1'b1;
    cyc();
    wait_cond(C_LOADGO, 20, "t4_loadgo_timeout");
    check("t4_gen_inc", 32'(o_gen_count), 32'(exp_g));
    wait_cond(C_OWN0, 40, "t4_reload_timeout");
    check("t4_not_paused", 32'(o_running), 32'd1);

    // Reset during LOADING.
    i_reload = 1'b1;
    cyc();
    wait_cond(C_BUSY, 10, "t5_busy_timeout");
    cyc();
    rst_n = 1'b0;
    cyc();
    check("t5_load_go", 32'(o_load_go), 32'd0);
    check("t5_step_go", 32'(o_step_go), 32'd0);
    check("t5_owner",   32'(o_mem_owner), 32'd0);
    check("t5_running", 32'(o_running), 32'd0);
    check("t5_gen",     32'(o_gen_count), 32'd0);
    rst_n = 1'b1;
    cyc();

`ifdef GOL_RUN_CTRL_SINGLE_STEP_EN
    i_start = 1'b1;
    cyc();
    wait_cond(C_OWN0, 40, "t6_load_timeout");
    i_single_step = 1'b1;
    cyc();
    check("t6_ignored_in_run", 32'(o_step_go), 32'd0);
    i_pause = 1'b1;
    cyc();
    exp_g = (m_gen + 1) % (1 << GEN_CNT_W);
    i_single_step = 1'b1;
    cyc();
    check("t6_step_go", 32'(o_step_go), 32'd1);
    wait_cond(C_OWN0, 20, "t6_done_timeout");
    check("t6_gen_inc", 32'(o_gen_count), 32'(exp_g));
    check("t6_paused", 32'(o_running), 32'd0);
    repeat (10) cyc();
`endif

    // Randomized control pulses, including stray step_done outside stepping.
    i_start = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 29) == 0) i_start = 1'b1;
      if ($urandom_range(0, 24) == 0) i_pause = 1'b1;
      if ($urandom_range(0, 59) == 0) i_reload = 1'b1;
      if ($urandom_range(0, 19) == 0) i_single_step = 1'b1;
      cyc();
      if (!i_step_done && m_mode != M_STEP && $urandom_range(0, 39) == 0) i_step_done = 1'b1;
    end
    repeat (30) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
